// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline: bus widths, EXE->MEM / MEM->WB field
// offsets, mem_size (funct3) encodings and the memory-stage FSM encoding.
package pipeline_pkg;

  localparam int EXE_MEM_W = 110;
  localparam int MEM_WB_W  = 73;

  // EXE->MEM bus field LSB positions
  localparam int EM_PC_LSB    = 0;
  localparam int EM_WBSEL_LSB = 32;
  localparam int EM_RE_BIT    = 35;
  localparam int EM_WE_BIT    = 36;
  localparam int EM_RDWEN_BIT = 37;
  localparam int EM_RD_LSB    = 38;
  localparam int EM_SIZE_LSB  = 43;
  localparam int EM_SDATA_LSB = 46;
  localparam int EM_ALU_LSB   = 78;

  // MEM->WB bus field LSB positions
  localparam int MW_PC_LSB     = 0;
  localparam int MW_WBSEL_LSB  = 32;
  localparam int MW_RDWEN_BIT  = 35;
  localparam int MW_RD_LSB     = 36;
  localparam int MW_WBDATA_LSB = 41;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

  // Legal size code for the access direction and naturally aligned address
  function automatic logic access_ok(input logic [2:0] size,
                                     input logic [1:0] addr_lo,
                                     input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (addr_lo[0] == 1'b0);
      SIZE_W:  ok = (addr_lo == 2'b00);
      SIZE_BU: ok = !is_store;
      SIZE_HU: ok = !is_store && (addr_lo[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store data/strobe placement and load
// extraction with sign or zero extension.
module mem_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_size,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store strobes and lane-replicated write data
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    case (mem_size)
      SIZE_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      SIZE_W: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    load_data = 32'h0000_0000;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (mem_size)
      SIZE_B:  load_data = {{24{byte_s[7]}}, byte_s};
      SIZE_H:  load_data = {{16{half_s[15]}}, half_s};
      SIZE_W:  load_data = rdata;
      SIZE_BU: load_data = {24'h00_0000, byte_s};
      SIZE_HU: load_data = {16'h0000, half_s};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EXE->MEM bus, runs loads/stores
// over a req/gnt/rvalid port, and produces the MEM->WB bus.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int BUS_IN_W  = EXE_MEM_W,
  parameter int BUS_OUT_W = MEM_WB_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BUS_IN_W-1:0]  exe_mem_bus_in,
  output logic                 stall_out,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_wstrb,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [31:0]          dmem_rdata,
  output logic                 mem_wb_valid,
  output logic [BUS_OUT_W-1:0] mem_wb_bus_out,
  output logic                 misalign_err
);

  logic                valid_r;
  logic [BUS_IN_W-1:0] bus_r;
  mem_state_e          state_r;
  mem_state_e          state_s;

  logic [31:0] alu_s;
  logic [31:0] sdata_s;
  logic [2:0]  size_s;
  logic [4:0]  rd_s;
  logic        rd_wen_s;
  logic        mem_we_s;
  logic        mem_re_s;
  logic [2:0]  wb_sel_s;
  logic [31:0] pc_s;

  logic        mem_op_s;
  logic        misalign_s;
  logic        go_s;
  logic        req_s;
  logic        stall_s;
  logic        wb_valid_s;
  logic [3:0]  strb_s;
  logic [31:0] wdata_s;
  logic [31:0] load_s;
  logic [31:0] wb_data_s;

  assign alu_s    = bus_r[EM_ALU_LSB +: 32];
  assign sdata_s  = bus_r[EM_SDATA_LSB +: 32];
  assign size_s   = bus_r[EM_SIZE_LSB +: 3];
  assign rd_s     = bus_r[EM_RD_LSB +: 5];
  assign rd_wen_s = bus_r[EM_RDWEN_BIT];
  assign mem_we_s = bus_r[EM_WE_BIT];
  assign mem_re_s = bus_r[EM_RE_BIT];
  assign wb_sel_s = bus_r[EM_WBSEL_LSB +: 3];
  assign pc_s     = bus_r[EM_PC_LSB +: 32];

  assign mem_op_s   = valid_r && (mem_we_s || mem_re_s);
  assign misalign_s = mem_op_s &&
                      ((mem_we_s && mem_re_s) || !access_ok(size_s, alu_s[1:0], mem_we_s));
  assign go_s       = mem_op_s && !misalign_s;

  mem_align u_align (
    .addr_lo    (alu_s[1:0]),
    .mem_size   (size_s),
    .store_data (sdata_s),
    .rdata      (dmem_rdata),
    .wstrb      (strb_s),
    .wdata      (wdata_s),
    .load_data  (load_s)
  );

  // Stage register: captures the upstream bus whenever not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      bus_r   <= '0;
    end else if (!stall_s) begin
      valid_r <= in_valid;
      bus_r   <= exe_mem_bus_in;
    end else begin
      valid_r <= valid_r;
      bus_r   <= bus_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, request, stall and write-back valid
  always_comb begin
    state_s    = state_r;
    req_s      = 1'b0;
    stall_s    = 1'b0;
    wb_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A fresh aligned op issues its request in the capture cycle itself
        if (go_s) begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          state_s = dmem_gnt ? ST_WAIT : ST_REQ;
        end else begin
          wb_valid_s = valid_r;
          state_s    = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (dmem_gnt) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          wb_valid_s = 1'b1;
          stall_s    = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          stall_s = 1'b1;
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign wb_data_s = (mem_re_s && !mem_we_s && !misalign_s) ? load_s : alu_s;

  assign stall_out    = stall_s;
  assign dmem_req     = req_s;
  assign dmem_we      = req_s && mem_we_s;
  assign dmem_addr    = req_s ? {alu_s[31:2], 2'b00} : 32'h0000_0000;
  assign dmem_wstrb   = (req_s && mem_we_s) ? strb_s : 4'b0000;
  assign dmem_wdata   = (req_s && mem_we_s) ? wdata_s : 32'h0000_0000;
  assign mem_wb_valid = wb_valid_s;
  assign misalign_err = misalign_s;
  assign mem_wb_bus_out = {wb_data_s, rd_s, rd_wen_s && !misalign_s, wb_sel_s, pc_s};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, back-pressure,
// misalignment, pass-through and reset in the middle of a transaction.
module tb_mem_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [109:0] exe_bus;
  logic         stall_out;
  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_wstrb;
  logic [31:0]  dmem_wdata;
  logic         dmem_gnt;
  logic         dmem_rvalid;
  logic [31:0]  dmem_rdata;
  logic         mem_wb_valid;
  logic [72:0]  mem_wb_bus_out;
  logic         misalign_err;

  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .exe_mem_bus_in (exe_bus),
    .stall_out      (stall_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_wb_valid   (mem_wb_valid),
    .mem_wb_bus_out (mem_wb_bus_out),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [109:0] mk_bus(input logic [31:0] alu, input logic [31:0] sd,
                                          input logic [2:0] size, input logic [4:0] rd,
                                          input logic rd_wen, input logic we, input logic re,
                                          input logic [2:0] wb_sel, input logic [31:0] pc);
    return {alu, sd, size, rd, rd_wen, we, re, wb_sel, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture, one gnt cycle, one rvalid cycle, checking both phases
  task automatic mem_txn(input string tag, input logic [109:0] b, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata, input logic [31:0] exp_wb, input logic exp_rdwen);
    exe_bus  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exe_bus  = '0;
    dmem_gnt = 1'b1;
    #1;
    check_eq({tag, "_req"},   dmem_req, 1'b1);
    check_eq({tag, "_stall"}, stall_out, 1'b1);
    check_eq({tag, "_addr"},  dmem_addr, exp_addr);
    check_eq({tag, "_we"},    dmem_we, exp_we);
    check_eq({tag, "_wstrb"}, dmem_wstrb, exp_wstrb);
    if (exp_we) check_eq({tag, "_wdata"}, dmem_wdata, exp_wdata);
    check_eq({tag, "_wbv0"},  mem_wb_valid, 1'b0);
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    check_eq({tag, "_wbv"},    mem_wb_valid, 1'b1);
    check_eq({tag, "_wbdata"}, mem_wb_bus_out[72:41], exp_wb);
    check_eq({tag, "_rdwen"},  mem_wb_bus_out[35], exp_rdwen);
    check_eq({tag, "_stall1"}, stall_out, 1'b0);
    check_eq({tag, "_req1"},   dmem_req, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check_eq({tag, "_wbv2"},   mem_wb_valid, 1'b0);
    check_eq({tag, "_stall2"}, stall_out, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, stall_out, 1'b0);
    check_eq({tag, "_req"},   dmem_req, 1'b0);
    check_eq({tag, "_we"},    dmem_we, 1'b0);
    check_eq({tag, "_addr"},  dmem_addr, 32'h0);
    check_eq({tag, "_wstrb"}, dmem_wstrb, 4'h0);
    check_eq({tag, "_wdata"}, dmem_wdata, 32'h0);
    check_eq({tag, "_wbv"},   mem_wb_valid, 1'b0);
    check_eq({tag, "_bus"},   mem_wb_bus_out, 73'h0);
    check_eq({tag, "_mis"},   misalign_err, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    exe_bus     = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Loads: LW aligned, LB / LBU at byte 3
    mem_txn("lw", mk_bus(32'h100, 32'h0, 3'b010, 5'd5, 1'b1, 1'b0, 1'b1, 3'd1, 32'h1000),
            32'h100, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    mem_txn("lb", mk_bus(32'h103, 32'h0, 3'b000, 5'd7, 1'b1, 1'b0, 1'b1, 3'd1, 32'h1004),
            32'h100, 1'b0, 4'b0000, 32'h0, 32'h80FFFFFF, 32'hFFFFFF80, 1'b1);
    mem_txn("lbu", mk_bus(32'h103, 32'h0, 3'b100, 5'd7, 1'b1, 1'b0, 1'b1, 3'd1, 32'h1008),
            32'h100, 1'b0, 4'b0000, 32'h0, 32'h80FFFFFF, 32'h00000080, 1'b1);
    mem_txn("lhu", mk_bus(32'h106, 32'h0, 3'b101, 5'd8, 1'b1, 1'b0, 1'b1, 3'd1, 32'h100C),
            32'h104, 1'b0, 4'b0000, 32'h0, 32'h9ABC1234, 32'h00009ABC, 1'b1);

    // Stores: SH at 0x202, SB at 0x201
    mem_txn("sh", mk_bus(32'h202, 32'h1234, 3'b001, 5'd3, 1'b1, 1'b1, 1'b0, 3'd0, 32'h1010),
            32'h200, 1'b1, 4'b1100, 32'h12341234, 32'h0, 32'h202, 1'b1);
    mem_txn("sb", mk_bus(32'h201, 32'hA5, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h1014),
            32'h200, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0, 32'h201, 1'b0);

    // Back-pressure: gnt low 3 cycles, rvalid 2 cycles after gnt; next op waits upstream
    exe_bus  = mk_bus(32'h300, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, 1'b1, 3'd1, 32'h3000);
    in_valid = 1'b1;
    tick();
    exe_bus  = mk_bus(32'h55, 32'h0, 3'b000, 5'd10, 1'b1, 1'b0, 1'b0, 3'd0, 32'h2000);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3);
      #1;
      check_eq("bp_req", dmem_req, 1'b1);
      check_eq("bp_addr", dmem_addr, 32'h300);
      check_eq("bp_stall", stall_out, 1'b1);
      tick();
    end
    dmem_gnt = 1'b0;
    #1;
    check_eq("bp_wait_stall", stall_out, 1'b1);
    check_eq("bp_wait_req", dmem_req, 1'b0);
    check_eq("bp_wait_pc", mem_wb_bus_out[31:0], 32'h3000);
    check_eq("bp_wait_wbv", mem_wb_valid, 1'b0);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    #1;
    check_eq("bp_rv_wbv", mem_wb_valid, 1'b1);
    check_eq("bp_rv_data", mem_wb_bus_out[72:41], 32'hCAFEF00D);
    check_eq("bp_rv_stall", stall_out, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    in_valid    = 1'b0;
    exe_bus     = '0;
    #1;
    check_eq("bp_next_wbv", mem_wb_valid, 1'b1);
    check_eq("bp_next_data", mem_wb_bus_out[72:41], 32'h55);
    check_eq("bp_next_pc", mem_wb_bus_out[31:0], 32'h2000);
    tick();

    // Misaligned LW at 0x102
    exe_bus  = mk_bus(32'h102, 32'h0, 3'b010, 5'd4, 1'b1, 1'b0, 1'b1, 3'd1, 32'h4000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exe_bus  = '0;
    #1;
    check_eq("mis_req", dmem_req, 1'b0);
    check_eq("mis_err", misalign_err, 1'b1);
    check_eq("mis_wbv", mem_wb_valid, 1'b1);
    check_eq("mis_rdwen", mem_wb_bus_out[35], 1'b0);
    check_eq("mis_rd", mem_wb_bus_out[40:36], 5'd4);
    check_eq("mis_stall", stall_out, 1'b0);
    tick();
    check_eq("mis_err_end", misalign_err, 1'b0);
    check_eq("mis_wbv_end", mem_wb_valid, 1'b0);

    // Non-memory ADD: same-cycle valid
    exe_bus  = mk_bus(32'h7, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h5000);
    in_valid = 1'b1;
    tick();
    check_eq("add_wbv", mem_wb_valid, 1'b1);
    check_eq("add_data", mem_wb_bus_out[72:41], 32'h7);
    check_eq("add_rdwen", mem_wb_bus_out[35], 1'b1);
    check_eq("add_stall", stall_out, 1'b0);

    // LW reaches WAIT, then reset in the middle of it
    exe_bus = mk_bus(32'h400, 32'h0, 3'b010, 5'd2, 1'b1, 1'b0, 1'b1, 3'd1, 32'h5004);
    tick();
    in_valid = 1'b0;
    exe_bus  = '0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    check_eq("wait_stall", stall_out, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11111111;
    #1;
    check_eq("stray_wbv", mem_wb_valid, 1'b0);
    tick();
    check_eq("stray_wbv2", mem_wb_valid, 1'b0);
    check_eq("stray_stall", stall_out, 1'b0);
    check_eq("stray_req", dmem_req, 1'b0);
    dmem_rvalid = 1'b0;

    // Post-reset FSM is IDLE: a new load requests immediately
    exe_bus  = mk_bus(32'h500, 32'h0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b1, 3'd1, 32'h6000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_req", dmem_req, 1'b1);
    check_eq("post_rst_addr", dmem_addr, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of exe_stage and upstream of the write-back stage.
- Registers the EXE→MEM bus, performs loads and stores on the data-memory port using a req/gnt/rvalid handshake, and aligns and extends load data.
- Stalls upstream while a memory transaction is outstanding.
- Emits the MEM→WB bus with a valid qualifier.

Parameters:
- BUS_IN_W, 110, width of exe_mem_bus_in.
- BUS_OUT_W, 73, width of mem_wb_bus_out.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  exe_mem_bus_in carries a real instruction.
- exe_mem_bus_in  input  110  fields MSB→LSB: {alu_result[31:0], store_data[31:0], mem_size[2:0], rd[4:0], rd_wen, mem_we, mem_re, wb_sel[2:0], pc[31:0]}.
- stall_out  output  1  upstream must hold its bus this cycle.
- dmem_req  output  1  memory request valid.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  32  word address: {alu_result[31:2], 2'b00}.
- dmem_wstrb  output  4  byte enables.
- dmem_wdata  output  32  store data shifted to its byte lane.
- dmem_gnt  input  1  request accepted.
- dmem_rvalid  input  1  response valid; returned for both loads and stores.
- dmem_rdata  input  32  load word.
- mem_wb_valid  output  1  mem_wb_bus_out is valid this cycle.
- mem_wb_bus_out  output  73  fields MSB→LSB: {wb_data[31:0], rd[4:0], rd_wen, wb_sel[2:0], pc[31:0]}.
- misalign_err  output  1  one-cycle pulse for a misaligned access.

Behaviour:
- Reset (asynchronous, active-high): stage register cleared, valid bit 0, FSM to IDLE.
  - All outputs 0, including stall_out, dmem_req and mem_wb_valid.
- Stage register capture: captures exe_mem_bus_in and in_valid on each edge where stall_out=0. When stall_out=1 it holds.
- mem_size encoding (funct3):
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is treated as misaligned.
- Misaligned condition:
  - Word access with addr[1:0]≠0.
  - Half access with addr[0]≠0.
  - mem_we and mem_re both set.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, register holds a valid, aligned memory op → go to REQ the same cycle (combinational): dmem_req=1, stall_out=1.
  - REQ: dmem_req held 1, with all dmem_* outputs stable, until dmem_gnt=1. Then go to WAIT.
  - WAIT: dmem_req=0, stall_out=1. When dmem_rvalid=1: mem_wb_valid=1, stall_out=0, next state IDLE.
  - Minimum occupancy of a memory op: 2 cycles (gnt in the first cycle, rvalid in the second).
  - A gnt and rvalid in the same REQ cycle is not permitted by the memory protocol.
- Non-memory op, or bubble:
  - mem_wb_valid = stored valid, in the same cycle (1-cycle stage latency).
  - wb_data = alu_result.
  - stall_out=0.
- Misaligned op:
  - No request is issued.
  - mem_wb_valid=1 for one cycle, with rd_wen forced to 0.
  - misalign_err=1 for that cycle.
  - stall_out=0.
- Stores:
  - dmem_wstrb: SB → 0001<<addr[1:0]; SH → 0011<<addr[1:0]; SW → 1111.
  - dmem_wdata: store_data replicated into the addressed lane.
  - wb_data = alu_result.
- Loads:
  - Byte/half selected from dmem_rdata by addr[1:0].
  - Sign-extended for LB/LH, zero-extended for LBU/LHU.
  - wb_data is driven combinationally from dmem_rdata in the rvalid cycle.
- Pass-through: rd, wb_sel and pc pass unchanged. rd_wen passes unchanged except on misalign.
- dmem_rvalid is ignored in IDLE and in REQ, which covers stale responses after reset.
- Reset mid-transaction abandons it. No retry is issued after reset.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - bus widths;
  - field offsets for the EXE→MEM and MEM→WB buses;
  - the mem_size encodings;
  - the FSM state encoding.
- One sub-module, mem_align:
  - combinational store lane shift and wstrb generation;
  - load extraction and extension.

Test Plan:
- LW aligned: alu_result=0x100, gnt on 1st cycle, rvalid with rdata=0xDEADBEEF on 2nd cycle.
  - dmem_addr=0x100, wstrb=0000.
  - wb_data=0xDEADBEEF, mem_wb_valid for 1 cycle.
  - stall_out high for exactly 1 cycle.
- LB / LBU at addr 0x103, rdata=0x80FFFFFF.
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
- SH at 0x202, store_data=0x1234.
  - wstrb=1100, wdata=0x12341234, dmem_we=1.
  - After rvalid: wb_data=0x202, rd_wen as given.
- Back-pressure: gnt held low for 3 cycles, then rvalid after 2 further cycles.
  - dmem_req and dmem_addr stable for 4 cycles.
  - stall_out high throughout.
  - Upstream bus not consumed until the rvalid cycle.
- LW at 0x102.
  - No dmem_req.
  - misalign_err=1 and mem_wb_valid=1 with rd_wen=0, for 1 cycle.
- Non-mem ADD result 0x7, followed by reset asserted mid-WAIT and a stray rvalid after reset.
  - ADD: mem_wb_valid the same cycle as capture, wb_data=0x7.
  - After reset: all outputs 0 and FSM in IDLE.
  - Stray rvalid: no mem_wb_valid.
